// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_queue
//  Purpose  : Instruction-fetch queue between the PC stage and decode.
//             Issues in-order requests to instruction memory, tracks them in
//             a circular slot array and hands completed words to decode in
//             program order. A flush empties the queue and arranges for the
//             responses still in flight to be dropped when they return.
//  Ports    : clk, rst            - clock, synchronous active-high reset
//             flush               - kill all queued and in-flight fetches
//             pc_i/pc_valid_i     - fetch address from the PC stage
//             pc_ready_o          - PC accepted this cycle
//             imem_req_o/addr_o   - memory request, word-aligned address
//             imem_gnt_i          - memory accepted the request
//             imem_rvalid_i/rdata - in-order read data return
//             instr_*_o           - head instruction, PC, misaligned flag
//             instr_ready_i       - decode consumes the head
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_queue #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [31:0] pc_i,
  input  logic        pc_valid_i,
  output logic        pc_ready_o,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  output logic        instr_misaligned_o,
  input  logic        instr_ready_i
);

  localparam int unsigned      c_ptr_w = $clog2(DEPTH);
  localparam int unsigned      c_cnt_w = c_ptr_w + 1;
  localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(DEPTH);

  // Pointers wrap naturally because DEPTH is a power of two.
  logic [c_ptr_w-1:0] alloc_ptr_q, alloc_ptr_d;
  logic [c_ptr_w-1:0] fill_ptr_q,  fill_ptr_d;
  logic [c_ptr_w-1:0] head_ptr_q,  head_ptr_d;
  logic [c_cnt_w-1:0] count_q,     count_d;
  // Granted but not yet filled; this is what becomes discard work on flush.
  logic [c_cnt_w-1:0] inflight_q,  inflight_d;
  logic [c_cnt_w-1:0] discard_cnt_q, discard_cnt_d;

  logic [31:0]      slot_pc_q   [DEPTH];
  logic [31:0]      slot_pc_d   [DEPTH];
  logic [31:0]      slot_data_q [DEPTH];
  logic [31:0]      slot_data_d [DEPTH];
  logic [DEPTH-1:0] slot_mis_q,  slot_mis_d;
  logic [DEPTH-1:0] slot_done_q, slot_done_d;

  logic w_grant;
  logic w_accept;
  logic w_drop;
  logic w_pop;
  logic w_head_valid;

  // Request side looks only at registered occupancy, so a pop never frees a
  // slot for a same-cycle grant and instr_ready_i never reaches imem_req_o.
  assign imem_req_o  = pc_valid_i & ~flush & ~rst & (count_q < c_full);
  assign imem_addr_o = {pc_i[31:2], 2'b00};
  assign w_grant     = imem_req_o & imem_gnt_i;
  assign pc_ready_o  = w_grant;

  // A beat is dropped while discards are owed; otherwise it fills a slot,
  // provided something is actually outstanding.
  assign w_drop   = imem_rvalid_i & (discard_cnt_q != '0);
  assign w_accept = imem_rvalid_i & (discard_cnt_q == '0) & (inflight_q != '0);

  assign w_head_valid = ~rst & (count_q != '0) & slot_done_q[head_ptr_q];
  assign w_pop        = w_head_valid & instr_ready_i & ~flush;

  assign instr_valid_o      = w_head_valid;
  assign instr_o            = w_head_valid ? slot_data_q[head_ptr_q] : NOP_INSTR;
  assign instr_pc_o         = w_head_valid ? slot_pc_q[head_ptr_q]   : 32'h0;
  assign instr_misaligned_o = w_head_valid & slot_mis_q[head_ptr_q];

  always_comb begin
    alloc_ptr_d   = alloc_ptr_q;
    fill_ptr_d    = fill_ptr_q;
    head_ptr_d    = head_ptr_q;
    count_d       = count_q + c_cnt_w'(w_grant) - c_cnt_w'(w_pop);
    inflight_d    = inflight_q + c_cnt_w'(w_grant) - c_cnt_w'(w_accept);
    discard_cnt_d = discard_cnt_q - c_cnt_w'(w_drop);
    slot_pc_d     = slot_pc_q;
    slot_data_d   = slot_data_q;
    slot_mis_d    = slot_mis_q;
    slot_done_d   = slot_done_q;

    if (w_grant) begin
      slot_pc_d[alloc_ptr_q]   = pc_i;
      slot_mis_d[alloc_ptr_q]  = (pc_i[1:0] != 2'b00);
      slot_done_d[alloc_ptr_q] = 1'b0;
      alloc_ptr_d              = alloc_ptr_q + 1'b1;
    end
    if (w_accept) begin
      slot_data_d[fill_ptr_q] = imem_rdata_i;
      slot_done_d[fill_ptr_q] = 1'b1;
      fill_ptr_d              = fill_ptr_q + 1'b1;
    end
    if (w_pop) begin
      head_ptr_d = head_ptr_q + 1'b1;
    end

    if (flush) begin
      // Everything still outstanding at memory must be dropped on return,
      // except a beat that lands in this very cycle (it has been consumed).
      discard_cnt_d = discard_cnt_q - c_cnt_w'(w_drop) + inflight_q
                      - c_cnt_w'(w_accept);
      alloc_ptr_d   = '0;
      fill_ptr_d    = '0;
      head_ptr_d    = '0;
      count_d       = '0;
      inflight_d    = '0;
      slot_done_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alloc_ptr_q   <= '0;
      fill_ptr_q    <= '0;
      head_ptr_q    <= '0;
      count_q       <= '0;
      inflight_q    <= '0;
      discard_cnt_q <= '0;
      slot_done_q   <= '0;
    end else begin
      alloc_ptr_q   <= alloc_ptr_d;
      fill_ptr_q    <= fill_ptr_d;
      head_ptr_q    <= head_ptr_d;
      count_q       <= count_d;
      inflight_q    <= inflight_d;
      discard_cnt_q <= discard_cnt_d;
      slot_done_q   <= slot_done_d;
    end
  end

  // Payload storage needs no reset: the done flags and count gate its use.
  always_ff @(posedge clk) begin
    slot_pc_q   <= slot_pc_d;
    slot_data_q <= slot_data_d;
    slot_mis_q  <= slot_mis_d;
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_queue
//  Purpose  : Self-checking bench for fetch_queue. A behavioural memory with
//             programmable latency answers grants; a scoreboard of granted
//             fetches predicts every output and is popped on consumption.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;

  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, flush, pc_valid_i, pc_ready_o, imem_req_o, imem_gnt_i;
  logic        imem_rvalid_i, instr_valid_o, instr_misaligned_o, instr_ready_i;
  logic [31:0] pc_i, imem_addr_o, imem_rdata_i, instr_o, instr_pc_o;

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .pc_i(pc_i), .pc_valid_i(pc_valid_i), .pc_ready_o(pc_ready_o),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .instr_valid_o(instr_valid_o), .instr_o(instr_o), .instr_pc_o(instr_pc_o),
    .instr_misaligned_o(instr_misaligned_o), .instr_ready_i(instr_ready_i)
  );

  typedef struct { logic [31:0] pc; logic [31:0] data; logic done; } ent_t;
  typedef struct { int due; logic [31:0] addr; logic live; } mem_t;

  ent_t sq[$];   // expected queue contents, oldest first
  mem_t mp[$];   // requests pending at the memory, in order

  int n_vec = 0, n_err = 0;
  int cyc = 0, lat = 1, n_pops = 0, n_grants = 0;
  logic last_grant;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    case (a)
      32'hBFC0_0000: mem_data = 32'h0050_0093;
      32'hBFC0_0004: mem_data = 32'h0010_0113;
      32'hBFC0_0008: mem_data = 32'h0020_81B3;
      default:       mem_data = a ^ 32'h1357_9BDF;
    endcase
  endfunction

  function automatic int dead_beats();
    int n = 0;
    foreach (mp[i]) if (!mp[i].live) n++;
    return n;
  endfunction

  // One clock cycle: present memory response, check outputs against the
  // scoreboard, then advance the scoreboard by what should have happened.
  task automatic cycle();
    logic exp_valid, exp_req;
    mem_t m;
    ent_t e;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    if (mp.size() > 0 && mp[0].due <= cyc) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = mem_data(mp[0].addr);
    end
    #2;
    exp_valid = !rst && sq.size() > 0 && sq[0].done;
    chk("instr_valid", 32'(instr_valid_o), 32'(exp_valid));
    if (exp_valid) begin
      chk("instr", instr_o, sq[0].data);
      chk("instr_pc", instr_pc_o, sq[0].pc);
      chk("misaligned", 32'(instr_misaligned_o), 32'(sq[0].pc[1:0] != 2'b00));
    end else begin
      chk("idle_instr", instr_o, NOP);
      chk("idle_pc", instr_pc_o, 32'h0);
      chk("idle_mis", 32'(instr_misaligned_o), 32'h0);
    end
    exp_req = pc_valid_i && !flush && !rst && sq.size() < DEPTH;
    chk("imem_req", 32'(imem_req_o), 32'(exp_req));
    chk("pc_ready", 32'(pc_ready_o), 32'(exp_req && imem_gnt_i));
    if (exp_req) chk("imem_addr", imem_addr_o, {pc_i[31:2], 2'b00});
    last_grant = exp_req && imem_gnt_i;

    if (rst) begin
      sq.delete();
      mp.delete();
    end else begin
      if (imem_rvalid_i) begin
        m = mp.pop_front();
        if (m.live) begin
          for (int i = 0; i < sq.size(); i++) begin
            if (!sq[i].done) begin
              sq[i].done = 1'b1;
              sq[i].data = mem_data(m.addr);
              break;
            end
          end
        end
      end
      if (exp_valid && instr_ready_i && !flush) begin
        void'(sq.pop_front());
        n_pops++;
      end
      if (last_grant) begin
        e.pc = pc_i; e.data = '0; e.done = 1'b0;
        sq.push_back(e);
        m.due = cyc + lat; m.addr = {pc_i[31:2], 2'b00}; m.live = 1'b1;
        mp.push_back(m);
        n_grants++;
      end
      if (flush) begin
        sq.delete();
        foreach (mp[i]) mp[i].live = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive(input logic pv, input logic [31:0] pc, input logic rdy,
                       input logic fl);
    pc_valid_i = pv; pc_i = pc; instr_ready_i = rdy; flush = fl;
  endtask

  task automatic drain(input int n);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    int base_pops, base_grants, k;
    rst = 1'b1; imem_gnt_i = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    imem_rvalid_i = 1'b0; imem_rdata_i = '0;
    @(posedge clk); #1;
    cycle();
    cycle();
    rst = 1'b0;
    chk("reset_count", 32'(dut.count_q), 32'h0);
    chk("reset_discard", 32'(dut.discard_cnt_q), 32'h0);

    // Streaming at one per cycle, latency 1
    lat = 1; base_pops = n_pops;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'hBFC0_0000 + 32'(4 * i), 1'b1, 1'b0);
      cycle();
    end
    drain(4);
    chk("stream_pops", 32'(n_pops - base_pops), 32'd3);

    // Full: six PCs offered with decode stalled
    base_grants = n_grants; k = 0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 32'hBFC0_0000 + 32'(4 * k), 1'b0, 1'b0);
      cycle();
      if (last_grant) k++;
    end
    chk("full_grants", 32'(n_grants - base_grants), 32'd4);
    drive(1'b1, 32'hBFC0_0000 + 32'(4 * k), 1'b1, 1'b0);  // single pop
    cycle();
    chk("no_grant_on_pop", 32'(last_grant), 32'h0);
    drive(1'b1, 32'hBFC0_0000 + 32'(4 * k), 1'b0, 1'b0);
    cycle();
    chk("grant_after_pop", 32'(last_grant), 32'h1);
    drain(8);

    // Flush with two fetches in flight
    lat = 3; base_pops = n_pops;
    drive(1'b1, 32'hBFC0_0010, 1'b0, 1'b0); cycle();
    drive(1'b1, 32'hBFC0_0014, 1'b0, 1'b0); cycle();
    drive(1'b1, 32'hBFC0_0018, 1'b1, 1'b1); cycle();
    drive(1'b1, 32'hBFC0_0100, 1'b1, 1'b0); cycle();
    drain(8);
    chk("flush2_pops", 32'(n_pops - base_pops), 32'd1);

    // Flush coinciding with the oldest of three responses
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'hBFC0_0200 + 32'(4 * i), 1'b0, 1'b0);
      cycle();
    end
    drive(1'b0, 32'h0, 1'b1, 1'b1); cycle();
    chk("discard_cnt", 32'(dut.discard_cnt_q), 32'(dead_beats()));
    chk("discard_is_2", 32'(dut.discard_cnt_q), 32'd2);
    base_pops = n_pops;
    drive(1'b1, 32'hBFC0_0300, 1'b1, 1'b0); cycle();
    drain(8);
    chk("flush3_pops", 32'(n_pops - base_pops), 32'd1);

    // Misaligned PC
    lat = 1;
    drive(1'b1, 32'hBFC0_0006, 1'b0, 1'b0); cycle();
    drive(1'b0, 32'h0, 1'b0, 1'b0); cycle();
    chk("mis_flag", 32'(instr_misaligned_o), 32'h1);
    chk("mis_pc", instr_pc_o, 32'hBFC0_0006);
    drain(3);

    // Reset mid-stream with three queued
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'hBFC0_0400 + 32'(4 * i), 1'b0, 1'b0);
      cycle();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0); cycle();
    rst = 1'b1;
    drive(1'b1, 32'hBFC0_0500, 1'b1, 1'b1); cycle();
    rst = 1'b0;
    chk("rst_count", 32'(dut.count_q), 32'h0);
    drive(1'b1, 32'hBFC0_0500, 1'b1, 1'b0); cycle();
    chk("rst_accept", 32'(last_grant), 32'h1);
    drain(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
